// File: rtl/regfile_wb_scheduler_if.sv
// ============================================================================
// regfile_wb_scheduler_if
// Issue, write-back, long-latency and regfile write-port bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_scheduler_if #(
  parameter int XLEN = 32
);
  logic            issue_valid_i;
  logic            issue_long_i;
  logic [4:0]      issue_rd_i;
  logic [4:0]      issue_rs1_i;
  logic [4:0]      issue_rs2_i;
  logic            issue_use_rs1_i;
  logic            issue_use_rs2_i;
  logic            stall_o;
  logic            wb_valid_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            lu_valid_i;
  logic [4:0]      lu_rd_i;
  logic [XLEN-1:0] lu_data_i;
  logic            lu_ready_o;
  logic            we3_o;
  logic [4:0]      a3_o;
  logic [XLEN-1:0] wd3_o;
  logic [31:0]     busy_o;
  logic            err_o;

  // Scheduler side
  modport slave (
    input  issue_valid_i, issue_long_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
    input  issue_use_rs1_i, issue_use_rs2_i,
    input  wb_valid_i, wb_rd_i, wb_data_i,
    input  lu_valid_i, lu_rd_i, lu_data_i,
    output stall_o, lu_ready_o, we3_o, a3_o, wd3_o, busy_o, err_o
  );

  // Decode / WB / LU / regfile side
  modport master (
    output issue_valid_i, issue_long_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
    output issue_use_rs1_i, issue_use_rs2_i,
    output wb_valid_i, wb_rd_i, wb_data_i,
    output lu_valid_i, lu_rd_i, lu_data_i,
    input  stall_o, lu_ready_o, we3_o, a3_o, wd3_o, busy_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
// ============================================================================
// regfile_wb_scheduler
// Regfile write-port arbiter (WB vs long-latency unit) with busy scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb_scheduler #(
  parameter int XLEN         = 32,
  parameter int MAX_LONG     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  regfile_wb_scheduler_if.slave  bus
);

  localparam int CW = $clog2(MAX_LONG + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_MAX_LONG     = CW'(MAX_LONG);
  localparam logic [SW-1:0] C_STARVE_LIMIT = SW'(STARVE_LIMIT);

  logic [31:0]     r_busy;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic            r_err;

  logic            w_lu_hs;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic            w_hazard;
  logic            w_stall;
  logic            w_accept;
  logic            w_inc;
  logic            w_dec;
  logic [31:0]     w_set_mask;
  logic [31:0]     w_clr_mask;
  logic [31:0]     w_busy_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [SW-1:0]   w_starve_nxt;
  logic            w_err_nxt;

  // Write-port arbitration: WB never stalls, so it always wins.
  always_comb begin
    w_lu_hs    = 1'b0;
    w_sel_rd   = bus.lu_rd_i;
    w_sel_data = bus.lu_data_i;
    if (bus.wb_valid_i) begin
      w_sel_rd   = bus.wb_rd_i;
      w_sel_data = bus.wb_data_i;
    end else begin
      w_lu_hs = bus.lu_valid_i & ~rst_i;
    end
  end

  always_comb begin
    w_hazard = 1'b0;
    if (bus.issue_use_rs1_i && r_busy[bus.issue_rs1_i]) w_hazard = 1'b1;
    if (bus.issue_use_rs2_i && r_busy[bus.issue_rs2_i]) w_hazard = 1'b1;
    if (r_busy[bus.issue_rd_i])                          w_hazard = 1'b1;
    if (bus.issue_long_i && (r_count == C_MAX_LONG))     w_hazard = 1'b1;
    if (r_starve == C_STARVE_LIMIT)                      w_hazard = 1'b1;
    w_stall  = rst_i | (bus.issue_valid_i & w_hazard);
    w_accept = bus.issue_valid_i & ~w_stall;
  end

  // Scoreboard next state; clear applied before set so a same-cycle set wins.
  always_comb begin
    w_inc      = w_accept & bus.issue_long_i;
    w_dec      = w_lu_hs & (r_count != '0);
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_inc && (bus.issue_rd_i != 5'd0)) w_set_mask = 32'd1 << bus.issue_rd_i;
    if (w_lu_hs && (bus.lu_rd_i != 5'd0))  w_clr_mask = 32'd1 << bus.lu_rd_i;
    w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;

    w_count_nxt = r_count;
    if (w_inc && !w_dec && (r_count != C_MAX_LONG)) w_count_nxt = r_count + CW'(1);
    else if (w_dec && !w_inc)                       w_count_nxt = r_count - CW'(1);

    w_starve_nxt = r_starve;
    if (w_lu_hs)
      w_starve_nxt = '0;
    else if (bus.wb_valid_i && bus.lu_valid_i && (r_starve != C_STARVE_LIMIT))
      w_starve_nxt = r_starve + SW'(1);

    w_err_nxt = r_err;
    if (w_lu_hs && (bus.lu_rd_i != 5'd0) && !r_busy[bus.lu_rd_i]) w_err_nxt = 1'b1;
    if (w_lu_hs && (r_count == '0))                                w_err_nxt = 1'b1;
    if (w_inc && !w_dec && (r_count == C_MAX_LONG))                w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_err    <= 1'b0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // x0 writes are suppressed but the LU handshake above still completes.
  assign bus.we3_o      = ~rst_i & (bus.wb_valid_i | bus.lu_valid_i) & (w_sel_rd != 5'd0);
  assign bus.a3_o       = w_sel_rd;
  assign bus.wd3_o      = w_sel_data;
  assign bus.lu_ready_o = w_lu_hs;
  assign bus.stall_o    = w_stall;
  assign bus.busy_o     = r_busy;
  assign bus.err_o      = r_err;

endmodule

`default_nettype wire
